// File: rtl/grant_hold_fsm.sv
// grant_hold_fsm
// Registers the winner of an upstream 8-input fixed-priority encoder as a
// one-hot grant. The grant is held until the served requester raises done.
// A one-cycle GAP state follows every release. A wrapping counter tracks
// the number of grants issued.
//
// Optional feature macro: GRANT_TIMEOUT_EN
//   defined   : a hold counter forces a release after MAX_HOLD cycles in BUSY
//               and pulses timeout for one cycle; done wins a same-cycle tie.
//   undefined : BUSY is left only on done; timeout is tied low.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   enc_valid  encoder has at least one request pending
//   enc_grant  encoder winning index
//   done       served requester releases the grant (sampled in BUSY only)
//   gnt        registered one-hot grant, zero when nothing is granted
//   gnt_id     registered index of the current or most recent grant
//   busy       high while a grant is held
//   timeout    one-cycle forced-release pulse
//   grant_cnt  total grants issued, wraps modulo 2**GCNT_W
module grant_hold_fsm #(
  parameter int NUM_REQ  = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5,
  parameter int GCNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enc_valid,
  input  logic [IDX_W-1:0]   enc_grant,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               busy,
  output logic               timeout,
  output logic [GCNT_W-1:0]  grant_cnt
);

  // Elaboration-time parameter legality check.
  if ((NUM_REQ != (2 ** IDX_W)) || (MAX_HOLD < 2) || (MAX_HOLD > (2 ** CNT_W))) begin : g_param_check
    $error("grant_hold_fsm: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  state_t              state_r, state_s;
  logic [NUM_REQ-1:0]  gnt_r, gnt_s;
  logic [IDX_W-1:0]    gnt_id_r, gnt_id_s;
  logic                busy_r, busy_s;
  logic [GCNT_W-1:0]   grant_cnt_r, grant_cnt_s;

  // Decode an index into a one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] one;
    one = {{(NUM_REQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

`ifdef GRANT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] hold_r, hold_s;
  logic             timeout_r, timeout_s;
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    gnt_id_s    = gnt_id_r;
    busy_s      = busy_r;
    grant_cnt_s = grant_cnt_r;
`ifdef GRANT_TIMEOUT_EN
    hold_s      = hold_r;
    timeout_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (enc_valid) begin
          state_s     = ST_BUSY;
          gnt_id_s    = enc_grant;
          gnt_s       = to_onehot(enc_grant);
          busy_s      = 1'b1;
          grant_cnt_s = grant_cnt_r + {{(GCNT_W-1){1'b0}}, 1'b1};
`ifdef GRANT_TIMEOUT_EN
          hold_s      = {CNT_W{1'b0}};
`endif
        end else begin
          gnt_s  = {NUM_REQ{1'b0}};
          busy_s = 1'b0;
        end
      end
      ST_BUSY: begin
        // done is checked first so it wins a tie with the timeout condition.
        if (done) begin
          state_s = ST_GAP;
          gnt_s   = {NUM_REQ{1'b0}};
          busy_s  = 1'b0;
        end
`ifdef GRANT_TIMEOUT_EN
        else if (hold_r == HOLD_LAST) begin
          state_s   = ST_GAP;
          gnt_s     = {NUM_REQ{1'b0}};
          busy_s    = 1'b0;
          timeout_s = 1'b1;
        end else begin
          // Counter stays below HOLD_LAST here, so this also saturates.
          hold_s = hold_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
`else
        else begin
          gnt_s = gnt_r;
        end
`endif
      end
      ST_GAP: begin
        // Turnaround cycle: enc_valid deliberately not sampled.
        state_s = ST_IDLE;
        gnt_s   = {NUM_REQ{1'b0}};
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = {NUM_REQ{1'b0}};
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      gnt_r       <= {NUM_REQ{1'b0}};
      gnt_id_r    <= {IDX_W{1'b0}};
      busy_r      <= 1'b0;
      grant_cnt_r <= {GCNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      gnt_id_r    <= gnt_id_s;
      busy_r      <= busy_s;
      grant_cnt_r <= grant_cnt_s;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  // Hold counter and timeout pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r    <= {CNT_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      hold_r    <= hold_s;
      timeout_r <= timeout_s;
    end
  end

  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_r;
  assign gnt_id    = gnt_id_r;
  assign busy      = busy_r;
  assign grant_cnt = grant_cnt_r;

endmodule

// File: tb/tb_grant_hold_fsm.sv
// Randomized self-checking bench for grant_hold_fsm. A cycle-level
// behavioural model (owner/age/cool-down bookkeeping) predicts every output.
// The counter is instantiated 4 bits wide so that wrap-around is reachable.
module tb_grant_hold_fsm;
  localparam int NUM_REQ  = 8;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 16;
  localparam int CNT_W    = 5;
  localparam int GCNT_W   = 4;
`ifdef GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enc_valid = 1'b0;
  logic [IDX_W-1:0]   enc_grant = 3'd0;
  logic               done = 1'b0;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_id;
  logic               busy;
  logic               timeout;
  logic [GCNT_W-1:0]  grant_cnt;

  grant_hold_fsm #(
    .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD),
    .CNT_W(CNT_W), .GCNT_W(GCNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enc_valid(enc_valid), .enc_grant(enc_grant),
    .done(done), .gnt(gnt), .gnt_id(gnt_id), .busy(busy),
    .timeout(timeout), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit m_held;
  int m_last_id;
  int m_age;      // cycles the current grant has been visible
  int m_cool;     // cycles after a release during which no grant may start
  int m_cnt;
  bit m_to;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 1'b0; m_last_id = 0; m_age = 0; m_cool = 0; m_cnt = 0; m_to = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    m_to = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (m_held) begin
      if (done) begin
        m_held = 1'b0; m_cool = 1;
      end else if (TO_EN && m_age >= MAX_HOLD) begin
        m_held = 1'b0; m_cool = 1; m_to = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (enc_valid) begin
      m_held = 1'b1; m_last_id = int'(enc_grant); m_age = 1;
      m_cnt = (m_cnt + 1) % (1 << GCNT_W);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_gnt;
    exp_gnt = m_held ? (32'd1 << m_last_id) : 32'd0;
    check_eq("gnt", 32'(gnt), exp_gnt);
    check_eq("gnt_id", 32'(gnt_id), 32'(m_last_id));
    check_eq("busy", 32'(busy), 32'(m_held));
    check_eq("timeout", 32'(timeout), 32'(m_to));
    check_eq("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
    check_eq("onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
    check_outputs();
  endtask

  initial begin
    model_reset();
    // Reset then idle
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();

    // Single grant, index 3, done five cycles later
    enc_valid = 1'b1; enc_grant = 3'd3;
    step();
    enc_valid = 1'b0;
    repeat (4) step();
    done = 1'b1;
    step();
    done = 1'b0;
    repeat (3) step();

    // No pre-emption, then back-to-back grant of index 7
    enc_valid = 1'b1; enc_grant = 3'd2;
    step();
    enc_grant = 3'd7;
    repeat (3) step();
    done = 1'b1;
    step();
    done = 1'b0;
    repeat (3) step();
    done = 1'b1;
    step();
    done = 1'b0; enc_valid = 1'b0;
    repeat (2) step();

    // Long hold on index 5 with done never asserted
    enc_valid = 1'b1; enc_grant = 3'd5;
    step();
    enc_valid = 1'b0;
    repeat (100) step();
    done = 1'b1;
    step();
    done = 1'b0;
    repeat (2) step();

    // done on the last hold cycle (tie), then held through GAP and IDLE
    enc_valid = 1'b1; enc_grant = 3'd1;
    step();
    enc_valid = 1'b0;
    repeat (MAX_HOLD - 1) step();
    done = 1'b1;
    repeat (4) step();
    done = 1'b0;
    repeat (2) step();

    // Counter wrap: 17 short grants
    for (int i = 0; i < 17; i++) begin
      enc_valid = 1'b1; enc_grant = IDX_W'($urandom);
      step();
      enc_valid = 1'b0; done = 1'b1;
      step();
      done = 1'b0;
      step();
    end

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      enc_valid = ($urandom_range(0, 2) != 0);
      enc_grant = IDX_W'($urandom);
      done = ($urandom_range(0, 7) == 0);
      step();
    end

    // Reset in the middle of a grant on index 0
    enc_valid = 1'b0; done = 1'b1;
    repeat (3) step();
    done = 1'b0; enc_valid = 1'b1; enc_grant = 3'd0;
    step();
    enc_valid = 1'b0;
    step();
    check_eq("pre_reset_gnt", 32'(gnt), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    step();
    rst_n = 1'b1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
